// File: rtl/oscillator_bank_if.sv
`default_nettype none
// =====================================================================
// Module  : oscillator_bank_if
// Brief   : Control, load and sample bus of the oscillator bank.
// Revision: 1.0
// =====================================================================
interface oscillator_bank_if #(
  parameter int VOICES          = 8,
  parameter int PHASE_WIDTH     = 32,
  parameter int AUDIO_BIT_WIDTH = 24
);
  localparam int c_voice_w = $clog2(VOICES);

  logic                       sample_tick;
  logic                       busy;
  logic                       overrun;

  logic                       load_valid;
  logic [c_voice_w-1:0]       load_voice;
  logic [PHASE_WIDTH-1:0]     load_increment;
  logic [7:0]                 load_duty;
  logic [1:0]                 load_wave;
  logic                       load_enable;
  logic                       load_clear;

  logic                       sample_valid;
  logic [c_voice_w-1:0]       sample_voice;
  logic [AUDIO_BIT_WIDTH-1:0] sample_data;
  logic                       mix_valid;
  logic [AUDIO_BIT_WIDTH-1:0] mix_data;

  modport master (
    output sample_tick, load_valid, load_voice, load_increment,
           load_duty, load_wave, load_enable, load_clear,
    input  busy, overrun, sample_valid, sample_voice, sample_data,
           mix_valid, mix_data
  );

  modport slave (
    input  sample_tick, load_valid, load_voice, load_increment,
           load_duty, load_wave, load_enable, load_clear,
    output busy, overrun, sample_valid, sample_voice, sample_data,
           mix_valid, mix_data
  );
endinterface
`default_nettype wire

// File: rtl/oscillator_bank.sv
`default_nettype none
// =====================================================================
// Module  : oscillator_bank
// Brief   : Time-multiplexed DDS voices (sine/pulse/triangle/saw);
//           mixer present only when OSC_BANK_MIX_EN is defined.
// Revision: 1.0
// =====================================================================
module oscillator_bank #(
  parameter int VOICES          = 8,
  parameter int PHASE_WIDTH     = 32,
  parameter int AUDIO_BIT_WIDTH = 24
) (
  input wire logic         clock_50_000_000,
  input wire logic         reset,
  oscillator_bank_if.slave bus
);
  localparam int c_voice_w = $clog2(VOICES);
  localparam int c_aw      = AUDIO_BIT_WIDTH;
  localparam logic [c_voice_w-1:0] c_last = c_voice_w'(VOICES - 1);
  localparam logic [c_aw-1:0]      c_mid  = {1'b1, {(c_aw-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [c_voice_w-1:0]   r_idx;
  logic [PHASE_WIDTH-1:0] r_phase  [VOICES];
  logic [PHASE_WIDTH-1:0] r_inc    [VOICES];
  logic [7:0]             r_duty   [VOICES];
  logic [1:0]             r_wave   [VOICES];
  logic                   r_enable [VOICES];

  logic                   r_overrun;
  logic                   r_sample_valid;
  logic [c_voice_w-1:0]   r_sample_voice;
  logic [c_aw-1:0]        r_sample_data;

  logic                   w_load_hit;
  logic [c_aw-1:0]        w_p, w_p2, w_tri, w_pulse, w_sine, w_wave;
  logic [1:0]             w_quad;
  logic [7:0]             w_lidx, w_lidx_m;
  logic [c_aw-2:0]        w_mag;
  logic [c_aw-2:0]        w_lut [256];

  // Quarter-wave magnitude sampled at bucket centres so the mirrored quadrants stay exactly symmetric.
  function automatic logic [AUDIO_BIT_WIDTH-2:0] sine_q(input int k);
    longint t, t2, term, s, amp, r;
    t    = (longint'(2 * k + 1) * 64'sd1686629713) / 64'sd512;
    t2   = (t * t) >>> 30;
    term = t;
    s    = t;
    for (int n = 1; n <= 6; n++) begin
      term = -(((term * t2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
      s    = s + term;
    end
    amp = (64'sd1 <<< (AUDIO_BIT_WIDTH - 1)) - 64'sd1;
    r   = (s * amp) >>> 30;
    return r[AUDIO_BIT_WIDTH-2:0];
  endfunction

  generate
    for (genvar k = 0; k < 256; k++) begin : g_lut
      assign w_lut[k] = sine_q(k);
    end
    if (PHASE_WIDTH >= AUDIO_BIT_WIDTH) begin : g_p_trunc
      assign w_p = r_phase[r_idx][PHASE_WIDTH-1 -: AUDIO_BIT_WIDTH];
    end else begin : g_p_pad
      assign w_p = {r_phase[r_idx], {(AUDIO_BIT_WIDTH-PHASE_WIDTH){1'b0}}};
    end
  endgenerate

  assign w_p2     = {w_p[c_aw-2:0], 1'b0};
  assign w_tri    = w_p[c_aw-1] ? ~w_p2 : w_p2;
  assign w_pulse  = (w_p[c_aw-1 -: 8] < r_duty[r_idx]) ? {c_aw{1'b1}} : {c_aw{1'b0}};
  assign w_quad   = w_p[c_aw-1 -: 2];
  assign w_lidx   = w_p[c_aw-3 -: 8];
  assign w_lidx_m = w_quad[0] ? ~w_lidx : w_lidx;
  assign w_mag    = w_lut[w_lidx_m];
  assign w_sine   = w_quad[1] ? (c_mid - {1'b0, w_mag}) : (c_mid + {1'b0, w_mag});

  always_comb begin
    w_wave = c_mid;
    if (r_enable[r_idx]) begin
      case (r_wave[r_idx])
        2'd0:    w_wave = w_sine;
        2'd1:    w_wave = w_pulse;
        2'd2:    w_wave = w_tri;
        default: w_wave = w_p;
      endcase
    end
  end

  assign w_load_hit = bus.load_valid &&
                      ({{(32-c_voice_w){1'b0}}, bus.load_voice} < 32'(VOICES));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (bus.sample_tick) w_next_state = S_SWEEP;
      S_SWEEP: if (r_idx == c_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_idx          <= '0;
      r_overrun      <= 1'b0;
      r_sample_valid <= 1'b0;
      r_sample_voice <= '0;
      r_sample_data  <= c_mid;
      for (int v = 0; v < VOICES; v++) begin
        r_phase[v]  <= '0;
        r_inc[v]    <= '0;
        r_duty[v]   <= 8'd128;
        r_wave[v]   <= 2'd0;
        r_enable[v] <= 1'b0;
      end
    end else begin
      r_state        <= w_next_state;
      r_sample_valid <= 1'b0;
      if (r_state == S_SWEEP) begin
        r_idx <= r_idx + c_voice_w'(1);
      end else begin
        r_idx <= '0;
      end
      if (bus.sample_tick && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
      if (r_state == S_SWEEP) begin
        r_sample_valid <= 1'b1;
        r_sample_voice <= r_idx;
        r_sample_data  <= w_wave;
        if (r_enable[r_idx]) begin
          r_phase[r_idx] <= r_phase[r_idx] + r_inc[r_idx];
        end
      end
      // Placed after the sweep update so a same-cycle clear wins over the increment.
      if (w_load_hit) begin
        r_inc[bus.load_voice]    <= bus.load_increment;
        r_duty[bus.load_voice]   <= bus.load_duty;
        r_wave[bus.load_voice]   <= bus.load_wave;
        r_enable[bus.load_voice] <= bus.load_enable;
        if (bus.load_clear) begin
          r_phase[bus.load_voice] <= '0;
        end
      end
    end
  end

  assign bus.busy         = (r_state != S_IDLE);
  assign bus.overrun      = r_overrun;
  assign bus.sample_valid = r_sample_valid;
  assign bus.sample_voice = r_sample_voice;
  assign bus.sample_data  = r_sample_data;

`ifdef OSC_BANK_MIX_EN
  localparam int c_acc_w = c_aw + c_voice_w + 1;
  localparam int c_shift = c_voice_w / 2;
  localparam logic signed [c_acc_w-1:0] c_sat_hi =
    c_acc_w'((64'sd1 <<< (c_aw - 1)) - 64'sd1);
  localparam logic signed [c_acc_w-1:0] c_sat_lo =
    c_acc_w'(-(64'sd1 <<< (c_aw - 1)));

  logic signed [c_acc_w-1:0] r_acc;
  logic signed [c_acc_w-1:0] w_dev, w_shifted, w_sat;
  logic                      r_mix_valid;
  logic [c_aw-1:0]           r_mix_data;

  assign w_dev     = c_acc_w'($signed({1'b0, w_wave}) - $signed({1'b0, c_mid}));
  assign w_shifted = r_acc >>> c_shift;

  always_comb begin
    w_sat = w_shifted;
    if (w_shifted > c_sat_hi) begin
      w_sat = c_sat_hi;
    end else if (w_shifted < c_sat_lo) begin
      w_sat = c_sat_lo;
    end
  end

  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      r_acc       <= '0;
      r_mix_valid <= 1'b0;
      r_mix_data  <= c_mid;
    end else begin
      r_mix_valid <= 1'b0;
      if ((r_state == S_IDLE) && bus.sample_tick) begin
        r_acc <= '0;
      end else if ((r_state == S_SWEEP) && r_enable[r_idx]) begin
        r_acc <= r_acc + w_dev;
      end
      if (r_state == S_DONE) begin
        r_mix_valid <= 1'b1;
        // Flipping the MSB of a two's-complement value adds midscale.
        r_mix_data  <= w_sat[c_aw-1:0] ^ c_mid;
      end
    end
  end

  assign bus.mix_valid = r_mix_valid;
  assign bus.mix_data  = r_mix_data;
`else
  assign bus.mix_valid = 1'b0;
  assign bus.mix_data  = c_mid;
`endif
endmodule
`default_nettype wire
